// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner for up to 16 hex digits, with dead-time
// blanking, a frame-coherent input snapshot, leading-zero suppression and blink.
module seg7_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  blank_lz,
    input  logic                  en,
    output logic [DIGITS-1:0]     dig,
    output logic [7:0]            segm,
    output logic                  frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [FW-1:0]       fcnt;
    logic                bph;
    logic [4*DIGITS-1:0] snap_num;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   snap_blink;

    logic                slot_wrap;
    logic                frame_wrap;
    logic                frame_start;
    logic                dead;
    logic                upper_zero;
    logic                lz_blank;
    logic                blink_blank;
    logic [3:0]          cur_nib;
    logic [DIGITS-1:0]   dig_nxt;
    logic [7:0]          segm_nxt;

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'h40;
            4'h1: hex_font = 7'h79;
            4'h2: hex_font = 7'h24;
            4'h3: hex_font = 7'h30;
            4'h4: hex_font = 7'h19;
            4'h5: hex_font = 7'h12;
            4'h6: hex_font = 7'h02;
            4'h7: hex_font = 7'h78;
            4'h8: hex_font = 7'h00;
            4'h9: hex_font = 7'h18;
            4'hA: hex_font = 7'h08;
            4'hB: hex_font = 7'h03;
            4'hC: hex_font = 7'h46;
            4'hD: hex_font = 7'h21;
            4'hE: hex_font = 7'h06;
            default: hex_font = 7'h0E;
        endcase
    endfunction

    assign slot_wrap   = (cnt == CW'(SCAN_DIV - 1));
    assign frame_wrap  = slot_wrap && (idx == IW'(DIGITS - 1));
    assign frame_start = (cnt == '0) && (idx == '0);
    assign dead        = (cnt < CW'(DEAD_CYCLES));
    assign cur_nib     = snap_num[{idx, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_wrap) begin
            cnt <= '0;
            idx <= frame_wrap ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt <= '0;
            bph  <= 1'b0;
        end else if (frame_wrap) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt <= '0;
                bph  <= ~bph;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // Loaded in the first (always dark) cycle of a frame so every digit of the frame sees one value.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_num   <= '0;
            snap_dp    <= '0;
            snap_blink <= '0;
        end else if (frame_start) begin
            snap_num   <= num;
            snap_dp    <= dp;
            snap_blink <= blink;
        end
    end

    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx) && snap_num[4*i +: 4] != 4'h0) upper_zero = 1'b0;
        end
    end

    assign lz_blank    = blank_lz && (idx != '0) && upper_zero;
    assign blink_blank = bph && snap_blink[idx];

    always_comb begin
        dig_nxt  = '1;
        segm_nxt = 8'hFF;
        if (en && !dead) begin
            dig_nxt = ~(DIGITS'(1) << idx);
            if (!(lz_blank || blink_blank)) segm_nxt = {~snap_dp[idx], hex_font(cur_nib)};
        end
    end

    // frame_done is registered from the wrap, so it is high exactly while state is (0,0)
    // after a real wrap; the (0,0) state left by reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig        <= '1;
            segm       <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            dig        <= dig_nxt;
            segm       <= segm_nxt;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios then random inputs, every cycle checked
// against a timeline model (cycle number -> frame, digit, phase) held in the bench.
module tb_seg7_scan_ctrl;

    localparam int D     = 8;
    localparam int SD    = 8;
    localparam int DC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = D * SD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4*D-1:0] num = '0;
    logic [D-1:0]  dp = '0;
    logic [D-1:0]  blink = '0;
    logic          blank_lz = 1'b0;
    logic          en = 1'b1;
    logic [D-1:0]  dig;
    logic [7:0]    segm;
    logic          frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;

    logic [31:0]   m_num = '0;
    logic [D-1:0]  m_dp = '0;
    logic [D-1:0]  m_blink = '0;
    logic [16:0]   exp_q[$];
    logic [7:0]    font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg7_scan_ctrl #(
        .DIGITS(D), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .num(num), .dp(dp), .blink(blink),
        .blank_lz(blank_lz), .en(en), .dig(dig), .segm(segm), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check();
        logic [16:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (frame_done === e[16]) else begin
            n_err++;
            $error("FAIL frame_done k=%0d observed %b expected %b", k, frame_done, e[16]);
        end
        n_cmp++;
        assert (dig === e[15:8]) else begin
            n_err++;
            $error("FAIL dig k=%0d observed %h expected %h", k, dig, e[15:8]);
        end
        n_cmp++;
        assert (segm === e[7:0]) else begin
            n_err++;
            $error("FAIL segm k=%0d observed %h expected %h", k, segm, e[7:0]);
        end
    endtask

    // k counts edges since reset released; the display position follows from k alone.
    task automatic tick();
        logic [7:0] e_dig;
        logic [7:0] e_segm;
        logic       e_fd;
        int         slot, di, ph, fr;
        logic [3:0] nib;
        logic       blanked;
        @(posedge clk);
        e_dig  = 8'hFF;
        e_segm = 8'hFF;
        e_fd   = 1'b0;
        if (rst) begin
            k       = 0;
            m_num   = '0;
            m_dp    = '0;
            m_blink = '0;
        end else begin
            if (k % FRAME == 0) begin
                m_num   = num;
                m_dp    = dp;
                m_blink = blink;
            end
            slot = k % FRAME;
            di   = slot / SD;
            ph   = slot % SD;
            fr   = k / FRAME;
            e_fd = ((k + 1) % FRAME == 0);
            if (en && ph >= DC) begin
                e_dig     = 8'hFF;
                e_dig[di] = 1'b0;
                nib       = 4'(m_num >> (4 * di));
                blanked   = (blank_lz && di != 0 && (m_num >> (4 * di)) == 0) ||
                            (((fr / BF) % 2 == 1) && m_blink[di]);
                e_segm    = blanked ? 8'hFF : {~m_dp[di], font[nib][6:0]};
            end
            k++;
        end
        exp_q.push_back({e_fd, e_dig, e_segm});
        @(negedge clk);
        check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align(input int pos);
        for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset held for three cycles, then plain scanning
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(2 * FRAME);

        // font and digit mapping
        num = 32'h89AB_CDEF;
        run(2 * FRAME);
        num = 32'h0123_4567;
        run(2 * FRAME);

        // leading-zero suppression
        blank_lz = 1'b1;
        num = 32'h0000_00A5;
        run(2 * FRAME);
        num = 32'h0;
        run(2 * FRAME);
        blank_lz = 1'b0;
        run(2 * FRAME);

        // input change while digit 3 is lit must wait for the next frame
        num = 32'h1111_1111;
        run(FRAME);
        align(3 * SD + 4);
        num = 32'h2222_2222;
        run(2 * FRAME);

        // decimal point and blink across six frames from a fresh reset
        num = 32'h0;
        dp = 8'h01;
        blink = 8'h80;
        pulse_rst();
        run(6 * FRAME);

        // enable drop mid digit 4, then reset during digit 5
        align(4 * SD + 4);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(FRAME);
        align(5 * SD + 4);
        pulse_rst();
        run(FRAME);

        // randomized inputs, enable and occasional reset
        for (int n = 0; n < 40; n++) begin
            num = $urandom();
            if ($urandom_range(0, 1) == 1) num = num >> (4 * $urandom_range(1, 7));
            dp       = 8'($urandom());
            blink    = 8'($urandom());
            blank_lz = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) pulse_rst();
            run($urandom_range(5, 90));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
